// File: rtl/photo_tape_reader.sv
// Buffered photo tape reader: host frames replayed as timed hole pulses.
// Define PHOTO_TAPE_REV_EN for reverse motion with history retention.
module photo_tape_reader #(
    parameter int FRAME_CYCLES = 2000,
    parameter int PULSE_CYCLES = 600,
    parameter int DEPTH        = 64
) (
    input  logic                       CLOCK,
    input  logic                       rst,
    input  logic [4:0]                 tape_data,
    input  logic                       tape_valid,
    output logic                       tape_ready,
    input  logic                       tape_clear,
    input  logic                       PHOTO_READER_FWD,
    input  logic                       PHOTO_READER_REV,
    output logic                       PL6_PHOTO1,
    output logic                       PL6_PHOTO2,
    output logic                       PL6_PHOTO3,
    output logic                       PL6_PHOTO4,
    output logic                       PL6_PHOTO5,
    output logic                       PHOTO_READER_PERMIT,
    output logic [$clog2(DEPTH):0]     unread_count
);

    localparam int AW = $clog2(DEPTH);

`ifdef PHOTO_TAPE_REV_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    typedef logic [AW:0] ptr_t;
    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    localparam ptr_t        DEPTH_W = ptr_t'(DEPTH);
    localparam ptr_t        ONE_W   = ptr_t'(1);
    localparam logic [15:0] P_W     = 16'(PULSE_CYCLES);
    localparam logic [15:0] F_LAST  = 16'(FRAME_CYCLES - 1);

    logic [4:0]  mem [DEPTH];
    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    ptr_t        base;
    ptr_t        unread;
    ptr_t        history;
    ptr_t        retained;
    ptr_t        rd_nxt;
    ptr_t        rd_m1;
    state_t      st;
    logic [15:0] cnt;
    logic [4:0]  photo;

    logic fwd;
    logic rev;
    logic wr_go;
    logic drop;
    logic fwd_go;
    logic rev_go;

    assign unread   = wr_ptr - rd_ptr;
    assign history  = rd_ptr - base;
    assign retained = wr_ptr - base;
    assign rd_m1    = rd_ptr - ONE_W;

    assign fwd = PHOTO_READER_FWD & ~PHOTO_READER_REV;
    assign rev = PHOTO_READER_REV & ~PHOTO_READER_FWD & REV_EN;

    assign tape_ready = (unread != DEPTH_W);
    assign wr_go      = tape_valid & tape_ready & ~tape_clear;
    assign drop       = wr_go & (retained == DEPTH_W);

    assign fwd_go = (st == IDLE) & fwd & (unread != '0);
    // Never step back onto the slot the same-cycle write is evicting.
    assign rev_go = (st == IDLE) & rev & (history != '0)
                  & ~(drop & (history == ONE_W));

    assign rd_nxt = rd_ptr + ptr_t'(fwd_go) - ptr_t'(rev_go);

    assign PHOTO_READER_PERMIT = (fwd & (unread != '0))
                               | (rev & (history != '0))
                               | (st != IDLE);

    assign unread_count = unread;

    assign PL6_PHOTO1 = photo[0];
    assign PL6_PHOTO2 = photo[1];
    assign PL6_PHOTO3 = photo[2];
    assign PL6_PHOTO4 = photo[3];
    assign PL6_PHOTO5 = photo[4];

    always_ff @(posedge CLOCK) begin
        if (wr_go) mem[wr_ptr[AW-1:0]] <= tape_data;
    end

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            base   <= '0;
            st     <= IDLE;
            cnt    <= '0;
            photo  <= '0;
        end else if (tape_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            base   <= '0;
            st     <= IDLE;
            cnt    <= '0;
            photo  <= '0;
        end else begin
            wr_ptr <= wr_ptr + ptr_t'(wr_go);
            rd_ptr <= rd_nxt;
            base   <= REV_EN ? base + ptr_t'(drop) : rd_nxt;
            unique case (st)
                IDLE: begin
                    if (fwd_go) begin
                        photo <= mem[rd_ptr[AW-1:0]];
                        cnt   <= 16'd1;
                        st    <= PULSE;
                    end else if (rev_go) begin
                        photo <= mem[rd_m1[AW-1:0]];
                        cnt   <= 16'd1;
                        st    <= PULSE;
                    end
                end
                PULSE: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == F_LAST) begin
                        photo <= '0;
                        st    <= IDLE;
                    end else if (cnt == P_W) begin
                        photo <= '0;
                        st    <= GAP;
                    end
                end
                GAP: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == F_LAST) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_photo_tape_reader.sv
// Directed bench for photo_tape_reader with a small frame pitch.
// Reverse expectations follow PHOTO_TAPE_REV_EN.
module tb_photo_tape_reader;

    localparam int F = 10;
    localparam int P = 3;
    localparam int D = 4;

    logic       CLOCK = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] tape_data = '0;
    logic       tape_valid = 1'b0;
    logic       tape_ready;
    logic       tape_clear = 1'b0;
    logic       PHOTO_READER_FWD = 1'b0;
    logic       PHOTO_READER_REV = 1'b0;
    logic       PL6_PHOTO1, PL6_PHOTO2, PL6_PHOTO3;
    logic       PL6_PHOTO4, PL6_PHOTO5;
    logic       PHOTO_READER_PERMIT;
    logic [2:0] unread_count;
    logic [4:0] photo;

    int checks = 0;
    int errors = 0;

    assign photo = {PL6_PHOTO5, PL6_PHOTO4, PL6_PHOTO3,
                    PL6_PHOTO2, PL6_PHOTO1};

    photo_tape_reader #(
        .FRAME_CYCLES(F),
        .PULSE_CYCLES(P),
        .DEPTH(D)
    ) dut (
        .CLOCK(CLOCK),
        .rst(rst),
        .tape_data(tape_data),
        .tape_valid(tape_valid),
        .tape_ready(tape_ready),
        .tape_clear(tape_clear),
        .PHOTO_READER_FWD(PHOTO_READER_FWD),
        .PHOTO_READER_REV(PHOTO_READER_REV),
        .PL6_PHOTO1(PL6_PHOTO1),
        .PL6_PHOTO2(PL6_PHOTO2),
        .PL6_PHOTO3(PL6_PHOTO3),
        .PL6_PHOTO4(PL6_PHOTO4),
        .PL6_PHOTO5(PL6_PHOTO5),
        .PHOTO_READER_PERMIT(PHOTO_READER_PERMIT),
        .unread_count(unread_count)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic wr(input logic [4:0] d);
        tape_data  = d;
        tape_valid = 1'b1;
        step();
        tape_valid = 1'b0;
    endtask

    task automatic clr();
        tape_clear = 1'b1;
        step();
        tape_clear = 1'b0;
    endtask

    // Sample k is taken 1ns after the k-th edge following frame start.
    task automatic watch(input int n, input int nf, input logic [4:0] f0,
                         input logic [4:0] f1, input logic [4:0] f2,
                         input bit chk_perm, input int flip);
        logic [4:0] fr [3];
        fr[0] = f0;
        fr[1] = f1;
        fr[2] = f2;
        for (int k = 0; k < n; k++) begin
            int fi;
            logic [4:0] exp;
            fi  = k / F;
            exp = (fi < nf && (k % F) < P) ? fr[fi] : 5'h00;
            check("photo", 32'(photo), 32'(exp));
            if (chk_perm)
                check("permit", 32'(PHOTO_READER_PERMIT),
                      32'(k < nf * F - 1));
            if (k == flip) begin
                PHOTO_READER_FWD = 1'b0;
                PHOTO_READER_REV = 1'b1;
            end
            step();
        end
    endtask

    initial begin
        #2;
        check("rst_photo", 32'(photo), 32'h0);
        check("rst_permit", 32'(PHOTO_READER_PERMIT), 32'h0);
        check("rst_ready", 32'(tape_ready), 32'h1);
        check("rst_unread", 32'(unread_count), 32'h0);
        step();
        step();
        rst = 1'b1;
        step();

        // three frames forward
        wr(5'h15);
        wr(5'h0A);
        wr(5'h1F);
        check("load3", 32'(unread_count), 32'd3);
        PHOTO_READER_FWD = 1'b1;
        step();
        check("unread_run", 32'(unread_count), 32'd2);
        watch(3 * F, 3, 5'h15, 5'h0A, 5'h1F, 1'b1, -1);
        check("unread_end", 32'(unread_count), 32'd0);

        // blank frame still takes a full period
        wr(5'h00);
        wr(5'h01);
        watch(2 * F, 2, 5'h00, 5'h01, 5'h00, 1'b1, -1);
        PHOTO_READER_FWD = 1'b0;

        // fill, back-pressure, clear mid-gap
        clr();
        for (int i = 1; i <= D; i++) wr(5'(i));
        check("full_cnt", 32'(unread_count), 32'(D));
        check("full_rdy", 32'(tape_ready), 32'h0);
        tape_data  = 5'h09;
        tape_valid = 1'b1;
        step();
        tape_valid = 1'b0;
        check("full_drop", 32'(unread_count), 32'(D));
        PHOTO_READER_FWD = 1'b1;
        step();
        check("rd_cnt", 32'(unread_count), 32'(D - 1));
        check("rd_rdy", 32'(tape_ready), 32'h1);
        check("rd_photo", 32'(photo), 32'h01);
        repeat (P) step();
        check("gap_photo", 32'(photo), 32'h0);
        tape_clear       = 1'b1;
        tape_valid       = 1'b1;
        tape_data        = 5'h05;
        PHOTO_READER_FWD = 1'b0;
        step();
        tape_clear = 1'b0;
        tape_valid = 1'b0;
        check("clr_cnt", 32'(unread_count), 32'h0);
        check("clr_photo", 32'(photo), 32'h0);
        check("clr_permit", 32'(PHOTO_READER_PERMIT), 32'h0);
        check("clr_rdy", 32'(tape_ready), 32'h1);
        step();
        check("clr_cnt2", 32'(unread_count), 32'h0);

        // forward then reverse
        wr(5'h01);
        wr(5'h02);
        wr(5'h03);
        PHOTO_READER_FWD = 1'b1;
        step();
        watch(3 * F, 3, 5'h01, 5'h02, 5'h03, 1'b1, -1);
        PHOTO_READER_FWD = 1'b0;
        PHOTO_READER_REV = 1'b1;
        step();
`ifdef PHOTO_TAPE_REV_EN
        watch(3 * F, 3, 5'h03, 5'h02, 5'h01, 1'b1, -1);
`else
        watch(3 * F, 0, 5'h00, 5'h00, 5'h00, 1'b1, -1);
`endif
        PHOTO_READER_REV = 1'b0;
        clr();

        // both directions is stop; flip mid-pulse is ignored
        wr(5'h07);
        PHOTO_READER_FWD = 1'b1;
        PHOTO_READER_REV = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("both_photo", 32'(photo), 32'h0);
            check("both_permit", 32'(PHOTO_READER_PERMIT), 32'h0);
        end
        check("both_cnt", 32'(unread_count), 32'd1);
        PHOTO_READER_REV = 1'b0;
        step();
        watch(F, 1, 5'h07, 5'h00, 5'h00, 1'b0, 1);
        PHOTO_READER_REV = 1'b0;
        clr();

        // async reset mid-pulse
        wr(5'h1F);
        PHOTO_READER_FWD = 1'b1;
        step();
        check("pre_rst", 32'(photo), 32'h1F);
        #2;
        rst = 1'b0;
        #1;
        check("arst_photo", 32'(photo), 32'h0);
        check("arst_cnt", 32'(unread_count), 32'h0);
        check("arst_rdy", 32'(tape_ready), 32'h1);
        check("arst_permit", 32'(PHOTO_READER_PERMIT), 32'h0);
        PHOTO_READER_FWD = 1'b0;
        step();
        rst = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/photo_tape_reader.md
# photo_tape_reader

Buffered photoelectric tape reader front end for the G-15 I/O section. Host software loads 5-bit tape frames into an internal ring buffer; the block replays them toward the I/O section as timed hole pulses on PL6_PHOTO1..5, obeying the PHOTO_READER_FWD/REV motion commands and reporting availability on PHOTO_READER_PERMIT. It sits directly upstream of the I/O section top level and drives its photo reader inputs.

## Interface
- FRAME_CYCLES, 2000: CLOCK cycles per tape frame (frame pitch); legal range 4..65535.
- PULSE_CYCLES, 600: cycles the hole pattern is driven at the start of each frame; 1 ≤ PULSE_CYCLES < FRAME_CYCLES.
- DEPTH, 64: ring buffer entries; power of two, ≥ 4.
- CLOCK  in  1  system clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- tape_data  in  5  host frame, bit 0 → channel 1 … bit 4 → channel 5.
- tape_valid  in  1  host frame offered.
- tape_ready  out  1  buffer accepts a frame this cycle.
- tape_clear  in  1  synchronous flush of all buffer contents.
- PHOTO_READER_FWD  in  1  I/O section requests forward motion.
- PHOTO_READER_REV  in  1  I/O section requests reverse motion.
- PL6_PHOTO1..PL6_PHOTO5  out  1 each  hole sensed, channels 1..5.
- PHOTO_READER_PERMIT  out  1  a frame is available in the commanded direction.
- unread_count  out  $clog2(DEPTH)+1  frames loaded but not yet read forward.

## Operation
- Pointers: wr_ptr, rd_ptr, base (oldest retained frame), all mod DEPTH, plus full-width counts unread = wr−rd, history = rd−base.
- Host write: accepted when tape_valid & tape_ready; tape_ready = (unread < DEPTH). Write lands at wr_ptr, wr_ptr++. If unread+history == DEPTH at accept, base++ (oldest history discarded).
- Motion decode: FWD & ~REV → forward; REV & ~FWD → reverse; both or neither → stop.
- States: IDLE, PULSE, GAP.
- IDLE: forward & unread≠0 → load frame at rd_ptr, rd_ptr++, → PULSE. Reverse & history≠0 → rd_ptr−−, load frame at new rd_ptr, → PULSE. Otherwise stay; photo outputs 0.
- PULSE: outputs = loaded frame; after PULSE_CYCLES cycles → GAP. Outputs 0 in GAP.
- GAP: at frame cycle FRAME_CYCLES−1 → IDLE. A frame once started always completes its full FRAME_CYCLES; motion commands are sampled only in IDLE.
- All-zero frames consume a full frame time with no pulse.
- PHOTO_READER_PERMIT = (forward & unread≠0) | (reverse & history≠0) | state≠IDLE.
- tape_clear: wr=rd=base=0, state → IDLE, outputs 0 next cycle; a simultaneous host write is dropped.
- Simultaneous host write and forward read in same cycle: both take effect; counts net correctly.

## Timing
- Reset (rst low, async): all pointers 0, state IDLE, PL6_PHOTO1..5 = 0, PERMIT = 0, tape_ready = 1, unread_count = 0. Reset mid-frame truncates the pulse immediately.
- Latency: IDLE with forward & data present at edge N → photo outputs valid from edge N+1 for exactly PULSE_CYCLES cycles.
- Frame period back-to-back: exactly FRAME_CYCLES cycles from one pulse start to next (IDLE occupies one cycle inside the period, counted).
- Write accepted at edge N is readable (unread_count updated) from edge N+1.
- Direction change mid-frame: no effect until the frame completes.
- Buffer empty while forward: outputs 0, PERMIT drops when frame completes; resumes one cycle after next write.

## Configuration
- PHOTO_TAPE_REV_EN defined: reverse motion and history retention as above.
- Not defined: base tracks rd_ptr (history always 0), REV-only decodes as stop, PERMIT ignores reverse; tape_ready = (unread < DEPTH) unchanged.

## Test plan
- Reset then load 0x15, 0x0A, 0x1F; hold FWD → three pulses 0x15,0x0A,0x1F each PULSE_CYCLES wide, FRAME_CYCLES apart; PERMIT falls after third frame; unread_count 3→0.
- Fill DEPTH frames with FWD low → tape_ready = 0 at unread_count = DEPTH; extra tape_valid not accepted; one forward read re-asserts tape_ready next cycle.
- Load 1,2,3, FWD read all, then REV → pulses 3,2,1 then PERMIT = 0 (with PHOTO_TAPE_REV_EN); without macro → no pulses, PERMIT = 0.
- Assert FWD and REV together with data loaded → no pulses, state stays IDLE; toggle direction mid-PULSE → current frame completes unchanged.
- Assert rst low mid-PULSE → outputs 0 asynchronously, unread_count = 0, tape_ready = 1; tape_clear mid-GAP with tape_valid high → buffer empty, write dropped.
- Load frame 0x00 then 0x01 under FWD → first frame period silent, second pulse exactly FRAME_CYCLES after the first frame started.
